// File: rtl/vend_ctrl.sv
// Vending transaction controller: select, credit check, timed dispense, change/refund payout.
// Optional `VEND_TIMEOUT_EN` adds an inactivity timer that refunds like a cancel.
module vend_ctrl #(
    parameter logic [11:0] PRICE1         = 12'd15,
    parameter logic [11:0] PRICE2         = 12'd25,
    parameter logic [11:0] PRICE3         = 12'd50,
    parameter logic [11:0] PRICE4         = 12'd100,
    parameter int          VEND_CYCLES    = 8,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] currency,
    input  logic [3:0]  goods_sel,
    input  logic        confirm,
    input  logic        cancel,
    output logic [3:0]  vend_led,
    output logic        short_led,
    output logic [11:0] change,
    output logic        change_valid,
    output logic        cash_clr,
    output logic        busy,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEL    = 3'd1,
        S_VEND   = 3'd2,
        S_PAYOUT = 3'd3,
        S_REFUND = 3'd4
    } state_t;

    localparam int VCW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

    state_t      state_q;
    logic [1:0]  item_q;
    logic [11:0] price_q;
    logic [11:0] pend_q;
    logic [11:0] change_q;
    logic        change_valid_q;
    logic        cash_clr_q;
    logic [3:0]  vend_led_q;
    logic [VCW-1:0] vcnt_q;

    logic        sel_hot;
    logic [1:0]  sel_idx;
    logic [11:0] sel_price;
    logic        abort;

    always_comb begin
        sel_hot   = 1'b1;
        sel_idx   = 2'd0;
        sel_price = PRICE1;
        case (goods_sel)
            4'b0001: begin sel_idx = 2'd0; sel_price = PRICE1; end
            4'b0010: begin sel_idx = 2'd1; sel_price = PRICE2; end
            4'b0100: begin sel_idx = 2'd2; sel_price = PRICE3; end
            4'b1000: begin sel_idx = 2'd3; sel_price = PRICE4; end
            default: sel_hot = 1'b0;
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic [11:0] cur_q;
    logic        to_run, to_act, to_fire;

    assign to_run  = (state_q == S_SEL) || (state_q == S_IDLE && currency != 12'd0);
    assign to_act  = (|goods_sel) || confirm || cancel || (currency != cur_q);
    assign to_fire = to_run && !to_act && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= 16'd0;
            cur_q    <= 12'd0;
        end else begin
            cur_q    <= currency;
            to_cnt_q <= (!to_run || to_act) ? 16'd0 : to_cnt_q + 16'd1;
        end
    end

    assign abort = cancel || to_fire;
`else
    assign abort = cancel;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            item_q         <= 2'd0;
            price_q        <= 12'd0;
            pend_q         <= 12'd0;
            change_q       <= 12'd0;
            change_valid_q <= 1'b0;
            cash_clr_q     <= 1'b0;
            vend_led_q     <= 4'd0;
            vcnt_q         <= '0;
        end else begin
            change_valid_q <= 1'b0;
            cash_clr_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (abort && currency != 12'd0) begin
                        state_q        <= S_REFUND;
                        change_q       <= currency;
                        change_valid_q <= 1'b1;
                        cash_clr_q     <= 1'b1;
                    end else if (sel_hot) begin
                        state_q <= S_SEL;
                        item_q  <= sel_idx;
                        price_q <= sel_price;
                    end
                end
                S_SEL: begin
                    if (abort) begin
                        state_q        <= S_REFUND;
                        change_q       <= currency;
                        change_valid_q <= 1'b1;
                        cash_clr_q     <= 1'b1;
                    end else if (sel_hot) begin
                        item_q  <= sel_idx;
                        price_q <= sel_price;
                    end else if (confirm && currency >= price_q) begin
                        state_q    <= S_VEND;
                        pend_q     <= currency - price_q;
                        vend_led_q <= 4'b0001 << item_q;
                        vcnt_q     <= VCW'(VEND_CYCLES - 1);
                    end
                end
                S_VEND: begin
                    // Change is published only at PAYOUT so `change` keeps its old value until the strobe.
                    if (vcnt_q == '0) begin
                        state_q        <= S_PAYOUT;
                        vend_led_q     <= 4'd0;
                        change_q       <= pend_q;
                        change_valid_q <= 1'b1;
                        cash_clr_q     <= 1'b1;
                    end else begin
                        vcnt_q <= vcnt_q - 1'b1;
                    end
                end
                S_PAYOUT, S_REFUND: state_q <= S_IDLE;
                default:            state_q <= S_IDLE;
            endcase
        end
    end

    assign vend_led     = vend_led_q;
    assign short_led    = (state_q == S_SEL) && (currency < price_q);
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign cash_clr     = cash_clr_q;
    assign busy         = (state_q == S_VEND) || (state_q == S_PAYOUT) || (state_q == S_REFUND);
    assign state        = state_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl: reset, purchase, short credit, cancel, reset mid-vend, timeout.
module tb_vend_ctrl;

    logic        clk;
    logic        rst;
    logic [11:0] currency;
    logic [3:0]  goods_sel;
    logic        confirm;
    logic        cancel;
    logic [3:0]  vend_led;
    logic        short_led;
    logic [11:0] change;
    logic        change_valid;
    logic        cash_clr;
    logic        busy;
    logic [2:0]  state;

    int passed = 0;
    int total  = 0;

    vend_ctrl #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .currency(currency), .goods_sel(goods_sel),
        .confirm(confirm), .cancel(cancel), .vend_led(vend_led), .short_led(short_led),
        .change(change), .change_valid(change_valid), .cash_clr(cash_clr),
        .busy(busy), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; currency = 12'd40; goods_sel = 4'b0001; confirm = 1'b0; cancel = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_vend_led", 32'(vend_led), 0);
        chk("rst_short", 32'(short_led), 0);
        chk("rst_change", 32'(change), 0);
        chk("rst_cv", 32'(change_valid), 0);
        chk("rst_clr", 32'(cash_clr), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_sel", 32'(state), 1);
        chk("post_rst_short", 32'(short_led), 0);
        goods_sel = 4'b0000;

        // Re-select item 2 (price 25) with 40 credit, then buy: change 15.
        goods_sel = 4'b0010; tick(); goods_sel = 4'b0000;
        chk("sel2_state", 32'(state), 1);
        confirm = 1'b1; tick(); confirm = 1'b0;
        chk("vend_state", 32'(state), 2);
        chk("vend_busy", 32'(busy), 1);
        chk("vend_chg_held", 32'(change), 0);
        chk("vend_led_c1", 32'(vend_led), 2);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk($sformatf("vend_led_c%0d", i), 32'(vend_led), 2);
        end
        tick();
        chk("pay_state", 32'(state), 3);
        chk("pay_led_off", 32'(vend_led), 0);
        chk("pay_change", 32'(change), 15);
        chk("pay_cv", 32'(change_valid), 1);
        chk("pay_clr", 32'(cash_clr), 1);
        tick();
        chk("pay_idle", 32'(state), 0);
        chk("pay_cv_off", 32'(change_valid), 0);
        chk("pay_chg_hold", 32'(change), 15);
        chk("pay_busy_off", 32'(busy), 0);

        // Short credit, then top-up to exact price: change 0 with strobes.
        currency = 12'd10; goods_sel = 4'b0001; tick(); goods_sel = 4'b0000;
        chk("short_on", 32'(short_led), 1);
        confirm = 1'b1; tick(); confirm = 1'b0;
        chk("short_stay", 32'(state), 1);
        chk("short_no_cv", 32'(change_valid), 0);
        currency = 12'd15; #1;
        chk("short_off_exact", 32'(short_led), 0);
        confirm = 1'b1; tick(); confirm = 1'b0;
        chk("exact_vend", 32'(state), 2);
        chk("exact_led", 32'(vend_led), 1);
        repeat (8) tick();
        chk("exact_pay", 32'(state), 3);
        chk("exact_change0", 32'(change), 0);
        chk("exact_cv", 32'(change_valid), 1);
        chk("exact_clr", 32'(cash_clr), 1);
        tick();

        // Cancel beats confirm in SELECTED.
        currency = 12'd60; goods_sel = 4'b0100; tick(); goods_sel = 4'b0000;
        chk("sel3_state", 32'(state), 1);
        cancel = 1'b1; confirm = 1'b1; tick(); cancel = 1'b0; confirm = 1'b0;
        chk("ref_state", 32'(state), 4);
        chk("ref_change", 32'(change), 60);
        chk("ref_cv", 32'(change_valid), 1);
        chk("ref_clr", 32'(cash_clr), 1);
        chk("ref_led", 32'(vend_led), 0);
        chk("ref_busy", 32'(busy), 1);
        tick();
        chk("ref_idle", 32'(state), 0);
        chk("ref_cv_off", 32'(change_valid), 0);

        // Multi-hot select and lone confirm ignored in IDLE; cancel with zero credit ignored.
        goods_sel = 4'b0110; tick(); goods_sel = 4'b0000;
        chk("multihot_idle", 32'(state), 0);
        confirm = 1'b1; tick(); confirm = 1'b0;
        chk("idle_confirm", 32'(state), 0);
        currency = 12'd0; cancel = 1'b1; tick(); cancel = 1'b0;
        chk("cancel_zero_state", 32'(state), 0);
        chk("cancel_zero_cv", 32'(change_valid), 0);

        // Re-select takes priority over confirm; item 4 costs more than the credit.
        currency = 12'd30; goods_sel = 4'b0001; tick();
        goods_sel = 4'b1000; confirm = 1'b1; tick(); goods_sel = 4'b0000; confirm = 1'b0;
        chk("resel_stay", 32'(state), 1);
        chk("resel_short", 32'(short_led), 1);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("resel_refund", 32'(change), 30);
        tick();

        // Reset during the third VEND cycle: no strobe, LEDs cleared.
        currency = 12'd40; goods_sel = 4'b0001; tick(); goods_sel = 4'b0000;
        confirm = 1'b1; tick(); confirm = 1'b0;
        tick(); tick();
        chk("midrst_vend", 32'(vend_led), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_led", 32'(vend_led), 0);
        chk("midrst_cv", 32'(change_valid), 0);
        chk("midrst_clr", 32'(cash_clr), 0);
        tick();
        chk("midrst_quiet", 32'(change_valid), 0);

        // Inactivity in SELECTED.
        currency = 12'd30; goods_sel = 4'b0001; tick(); goods_sel = 4'b0000;
        chk("to_sel", 32'(state), 1);
`ifdef VEND_TIMEOUT_EN
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                if (state == 3'd4) seen = 1'b1;
            end
            chk("to_reached", 32'(seen), 1);
            chk("to_change", 32'(change), 30);
            chk("to_cv", 32'(change_valid), 1);
        end
`else
        repeat (100) tick();
        chk("no_to_state", 32'(state), 1);
        chk("no_to_cv", 32'(change_valid), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
